hazard_sched: RTL and testbench

Pipeline hazard scheduler for the five-stage MIPS core. It drives the enable and clear inputs of the stage registers (PC, F/D, D/E, E/M, M/W) and the forwarding mux selects. It sequences load-use and branch-operand stalls, a multi-cycle mult/div occupancy window in Execute, and data-memory wait states. All outputs except the state and counter registers are combinational functions of the current inputs and state.

---
 rtl/mips_hazard_pkg.sv | 21 ++
 rtl/hazard_md_timer.sv | 51 +++++
 rtl/hazard_sched.sv | 103 ++++++++++
 tb/tb_hazard_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS pipeline hazard scheduler: forwarding selects,
// mult/div timer state encodings and the register-match helper.
package mips_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDWAIT = 1'b1
    } md_state_t;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] src,
                                       input logic [4:0] dst,
                                       input logic       we);
        return we && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Mult/div occupancy timer: tracks how long a mult/div still holds Execute.
// A held cycle (memory wait) freezes both the state and the countdown.
module hazard_md_timer
    import mips_hazard_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic busy,
    output logic done
);

    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    md_state_t     state;
    logic [CW-1:0] md_cnt;

    // The start cycle is already the first stall, so MDWAIT counts MD_LAT-2 down to 0
    // and releases Execute on the zero cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RUN;
            md_cnt <= '0;
        end else if (!hold) begin
            case (state)
                ST_RUN: begin
                    if (start) begin
                        state  <= ST_MDWAIT;
                        md_cnt <= CNT_LOAD;
                    end
                end
                ST_MDWAIT: begin
                    if (md_cnt != '0)
                        md_cnt <= md_cnt - CNT_ONE;
                    else
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign busy = (state == ST_MDWAIT);
    assign done = busy && (md_cnt == '0);

endmodule

// File: rtl/hazard_sched.sv
// Five-stage MIPS hazard scheduler: stage enables/clears and forwarding selects.
// Define HAZARD_FWD_EN to enable forwarding; otherwise every RAW dependency stalls in Decode.
module hazard_sched
    import mips_hazard_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       mem_to_reg_e,
    input  logic       mem_to_reg_m,
    input  logic       branch_d,
    input  logic       pc_src_d,
    input  logic       md_start_e,
    input  logic       mem_req_m,
    input  logic       mem_ready_m,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       md_busy
);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic mem_wait, md_stall, dec_stall;
    logic md_done;
    logic hit_e, hit_m;
    logic lwstall, brstall, raw_stall;
    logic [1:0] sel_a_e, sel_b_e;

    hazard_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .start (md_start_e),
        .hold  (mem_wait),
        .busy  (md_busy),
        .done  (md_done)
    );

    assign hit_e = reg_match(rs_d, write_reg_e, reg_write_e) | reg_match(rt_d, write_reg_e, reg_write_e);
    assign hit_m = reg_match(rs_d, write_reg_m, reg_write_m) | reg_match(rt_d, write_reg_m, reg_write_m);

    assign lwstall   = mem_to_reg_e & hit_e;
    assign brstall   = branch_d & (hit_e | (mem_to_reg_m & hit_m));
    assign raw_stall = ~FWD_ON & (hit_e | hit_m);

    // Priority: memory wait freezes everything, then mult/div occupancy, then Decode hazards.
    assign mem_wait  = mem_req_m & ~mem_ready_m;
    assign md_stall  = ~mem_wait & ((~md_busy & md_start_e) | (md_busy & ~md_done));
    assign dec_stall = ~mem_wait & ~md_stall & (lwstall | brstall | raw_stall);

    assign stall_f = mem_wait | md_stall | dec_stall;
    assign stall_d = mem_wait | md_stall | dec_stall;
    assign stall_e = mem_wait | md_stall;
    assign stall_m = mem_wait;

    assign flush_d = pc_src_d & ~stall_d;
    assign flush_e = dec_stall;
    assign flush_m = md_stall;
    assign flush_w = mem_wait;

    always_comb begin
        sel_a_e = FWD_RF;
        sel_b_e = FWD_RF;
        if (reg_match(rs_e, write_reg_m, reg_write_m))
            sel_a_e = FWD_MEM;
        else if (reg_match(rs_e, write_reg_w, reg_write_w))
            sel_a_e = FWD_WB;
        if (reg_match(rt_e, write_reg_m, reg_write_m))
            sel_b_e = FWD_MEM;
        else if (reg_match(rt_e, write_reg_w, reg_write_w))
            sel_b_e = FWD_WB;
    end

    assign fwd_a_e = FWD_ON ? sel_a_e : FWD_RF;
    assign fwd_b_e = FWD_ON ? sel_b_e : FWD_RF;
    assign fwd_a_d = FWD_ON & reg_match(rs_d, write_reg_m, reg_write_m);
    assign fwd_b_d = FWD_ON & reg_match(rt_d, write_reg_m, reg_write_m);

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed test-plan steps followed by
// randomized cycles, all checked against a cycle-level behavioural model.
module tb_hazard_sched;

    localparam int MD_LAT = 4;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, pc_src_d, md_start_e, mem_req_m, mem_ready_m;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic       fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       md_busy;

    int testCount = 0;
    int failCount = 0;
    int mdRemain  = 0;

    always #5 clk = ~clk;

    hazard_sched #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .branch_d(branch_d), .pc_src_d(pc_src_d), .md_start_e(md_start_e),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_busy(md_busy)
    );

    function automatic bit depends(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return (we == 1'b1) && (dst != 5'd0) && (src == dst);
    endfunction

    // mdRemain counts Execute cycles the mult/div still owns after the current one.
    function automatic logic [14:0] expected();
        bit memWait, mdStall, decStall, hitE, hitM, hazard, stall;
        logic [1:0] ae, be;
        memWait = mem_req_m && !mem_ready_m;
        if (memWait)
            mdStall = 0;
        else if (mdRemain == 0)
            mdStall = md_start_e;
        else
            mdStall = (mdRemain > 1);
        hitE = depends(rs_d, write_reg_e, reg_write_e) || depends(rt_d, write_reg_e, reg_write_e);
        hitM = depends(rs_d, write_reg_m, reg_write_m) || depends(rt_d, write_reg_m, reg_write_m);
        hazard = (mem_to_reg_e && hitE) || (branch_d && (hitE || (mem_to_reg_m && hitM)))
                 || (!FWD && (hitE || hitM));
        decStall = hazard && !memWait && !mdStall;
        stall = memWait || mdStall || decStall;
        ae = depends(rs_e, write_reg_m, reg_write_m) ? 2'd2 : depends(rs_e, write_reg_w, reg_write_w) ? 2'd1 : 2'd0;
        be = depends(rt_e, write_reg_m, reg_write_m) ? 2'd2 : depends(rt_e, write_reg_w, reg_write_w) ? 2'd1 : 2'd0;
        if (!FWD) begin
            ae = 2'd0;
            be = 2'd0;
        end
        return {stall, stall, memWait || mdStall, memWait,
                pc_src_d && !stall, decStall, mdStall, memWait,
                FWD && depends(rs_d, write_reg_m, reg_write_m),
                FWD && depends(rt_d, write_reg_m, reg_write_m),
                ae, be, mdRemain > 0};
    endfunction

    task automatic checkOutput(input string tag);
        logic [14:0] e;
        #1;
        e = expected();
        testCount++;
        assert ({stall_f, stall_d, stall_e, stall_m} === e[14:11]) else begin
            failCount++;
            $error("FAIL %s stalls: observed %b expected %b", tag, {stall_f, stall_d, stall_e, stall_m}, e[14:11]);
        end
        testCount++;
        assert ({flush_d, flush_e, flush_m, flush_w} === e[10:7]) else begin
            failCount++;
            $error("FAIL %s flushes: observed %b expected %b", tag, {flush_d, flush_e, flush_m, flush_w}, e[10:7]);
        end
        testCount++;
        assert ({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e} === e[6:1]) else begin
            failCount++;
            $error("FAIL %s fwd: observed %b expected %b", tag, {fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}, e[6:1]);
        end
        testCount++;
        assert (md_busy === e[0]) else begin
            failCount++;
            $error("FAIL %s md_busy: observed %b expected %b", tag, md_busy, e[0]);
        end
    endtask

    // Advance one clock edge and update the model's occupancy count.
    task automatic applyStimulus();
        @(posedge clk);
        if (reset)
            mdRemain = 0;
        else if (mem_req_m && !mem_ready_m)
            mdRemain = mdRemain;
        else if (mdRemain == 0)
            mdRemain = md_start_e ? MD_LAT - 1 : 0;
        else
            mdRemain = mdRemain - 1;
        @(negedge clk);
    endtask

    task automatic clearInputs();
        reset = 0;
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_to_reg_e = 0; mem_to_reg_m = 0;
        branch_d = 0; pc_src_d = 0; md_start_e = 0;
        mem_req_m = 0; mem_ready_m = 0;
    endtask

    initial begin
        clearInputs();
        reset = 1;
        @(negedge clk);
        applyStimulus();
        reset = 0;
        checkOutput("reset_idle");

        // Load-use on $2, then the load moves to M and the consumer to E.
        mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 2; rs_d = 2;
        checkOutput("lw_stall");
        applyStimulus();
        clearInputs();
        mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 2; rs_e = 2;
        checkOutput("lw_fwd");
        applyStimulus();
        clearInputs();

        // Mult/div occupancy with md_start_e held.
        md_start_e = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            checkOutput($sformatf("md_cycle%0d", i));
            applyStimulus();
        end
        md_start_e = 0;
        checkOutput("md_after");

        // Memory wait inside MDWAIT.
        md_start_e = 1;
        checkOutput("mdmem_start");
        applyStimulus();
        md_start_e = 0;
        mem_req_m = 1; mem_ready_m = 0;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("mdmem_wait%0d", i));
            applyStimulus();
        end
        mem_ready_m = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            checkOutput($sformatf("mdmem_tail%0d", i));
            applyStimulus();
        end
        clearInputs();

        // Taken branch on an E producer, then the producer in M.
        branch_d = 1; pc_src_d = 1; rs_d = 5; reg_write_e = 1; write_reg_e = 5;
        checkOutput("br_stall");
        applyStimulus();
        reg_write_e = 0; write_reg_e = 0; reg_write_m = 1; write_reg_m = 5;
        checkOutput("br_resolve");
        applyStimulus();
        clearInputs();

        // Register 0 never matches.
        write_reg_e = 0; rs_d = 0; mem_to_reg_e = 1; reg_write_e = 1; rs_e = 0; reg_write_m = 1;
        checkOutput("reg_zero");
        applyStimulus();
        clearInputs();

        // Synchronous reset mid-MDWAIT; a pulse between edges must do nothing.
        md_start_e = 1;
        applyStimulus();
        md_start_e = 0;
        reset = 1; #1; reset = 0;
        checkOutput("reset_pulse");
        applyStimulus();
        reset = 1;
        checkOutput("reset_pending");
        applyStimulus();
        reset = 0;
        checkOutput("reset_mdwait");

        // Randomized cycles with narrow register indices to force collisions.
        for (int n = 0; n < 400; n++) begin
            rs_d = 5'($urandom_range(0, 3));   rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3));   rt_e = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3));
            write_reg_m = 5'($urandom_range(0, 3));
            write_reg_w = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            mem_to_reg_e = 1'($urandom_range(0, 1));
            mem_to_reg_m = 1'($urandom_range(0, 1));
            branch_d = ($urandom_range(0, 2) == 0);
            pc_src_d = 1'($urandom_range(0, 1));
            md_start_e = ($urandom_range(0, 7) == 0);
            mem_req_m = ($urandom_range(0, 3) == 0);
            mem_ready_m = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 49) == 0);
            checkOutput($sformatf("rand%0d", n));
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
